// File: rtl/seg7_scan_mux_if.sv
// Bundles the per-digit pattern inputs, load strobe and scanned display outputs
// of the 7-segment scan multiplexer.
interface seg7_scan_mux_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic [7*NUM_DIGITS-1:0] seg_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    frame_done;

  modport master (
    output seg_in, dp_in, load,
    input  seg_out, dp_out, an_out, frame_done
  );

  modport slave (
    input  seg_in, dp_in, load,
    output seg_out, dp_out, an_out, frame_done
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// Double-buffered time-multiplexed driver for NUM_DIGITS active-low 7-segment digits
// with a blanking gap at the start of every digit slot.
module seg7_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_mux_if.slave    bus_io
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = 7 * NUM_DIGITS;

  localparam logic [TW-1:0] TIMER_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [TW-1:0]         timer_q, timer_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [0:0]            state_q, state_d;
  logic [SW-1:0]         shadow_seg_q, shadow_seg_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic                  pending_q, pending_d;
  logic [SW-1:0]         disp_seg_q, disp_seg_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;
  logic                  timer_wrap_s;
  logic                  boundary_s;

  // Slot timer, digit index and BLANK/DRIVE sequencing.
  always_comb begin
    timer_wrap_s = (timer_q == TIMER_LAST);
    boundary_s   = timer_wrap_s && (idx_q == IDX_LAST);

    if (timer_wrap_s) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    if (timer_wrap_s) begin
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      idx_d = idx_q;
    end

    case (state_q)
      ST_BLANK: begin
        if (timer_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_BLANK;
        end
      end
      ST_DRIVE: begin
        if (timer_wrap_s) begin
          state_d = ST_BLANK;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Shadow capture and frame-boundary transfer; a load on the boundary bypasses the shadow.
  always_comb begin
    shadow_seg_d = shadow_seg_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    disp_seg_d   = disp_seg_q;
    disp_dp_d    = disp_dp_q;
    if (boundary_s) begin
      if (bus_io.load) begin
        shadow_seg_d = bus_io.seg_in;
        shadow_dp_d  = bus_io.dp_in;
        disp_seg_d   = bus_io.seg_in;
        disp_dp_d    = bus_io.dp_in;
        pending_d    = 1'b0;
      end else if (pending_q) begin
        disp_seg_d   = shadow_seg_q;
        disp_dp_d    = shadow_dp_q;
        pending_d    = 1'b0;
      end else begin
        pending_d    = 1'b0;
      end
    end else if (bus_io.load) begin
      shadow_seg_d = bus_io.seg_in;
      shadow_dp_d  = bus_io.dp_in;
      pending_d    = 1'b1;
    end else begin
      pending_d    = pending_q;
    end
  end

  // Output values are derived from next-state so the registered outputs line up with the slot.
  always_comb begin
    frame_done_d = (timer_d == TIMER_LAST) && (idx_d == IDX_LAST);
    if (state_d == ST_DRIVE) begin
      seg_d = disp_seg_d[7*int'(idx_d) +: 7];
      dp_d  = disp_dp_d[int'(idx_d)];
    end else begin
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((state_d == ST_DRIVE) && (idx_d == IW'(i))) begin
        an_d[i] = 1'b0;
      end else begin
        an_d[i] = 1'b1;
      end
    end
  end

  // State, buffer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q      <= '0;
      idx_q        <= '0;
      state_q      <= ST_BLANK;
      shadow_seg_q <= '1;
      shadow_dp_q  <= '1;
      pending_q    <= 1'b0;
      disp_seg_q   <= '1;
      disp_dp_q    <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      shadow_seg_q <= shadow_seg_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      disp_seg_q   <= disp_seg_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus_io.seg_out    = seg_q;
  assign bus_io.dp_out     = dp_q;
  assign bus_io.an_out     = an_q;
  assign bus_io.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux with NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2
// (32-cycle frames): cycle-accurate scoreboard plus table and corner-case checks.
module tb_seg7_scan_mux;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = ND * DIV;

  logic clk;
  logic rst;

  seg7_scan_mux_if #(.NUM_DIGITS(ND)) bus_if ();

  seg7_scan_mux #(
    .NUM_DIGITS  (ND),
    .CLK_DIV     (DIV),
    .BLANK_CYCLES(BLK)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
  } outs_t;

  typedef struct {
    logic [ND-1:0][6:0] seg;
    logic [ND-1:0]      dp;
    int                 load_at;
    logic [ND-1:0][6:0] exp_seg;
    logic [ND-1:0]      exp_dp;
  } vec_t;

  int n_checks;
  int n_errors;
  outs_t exp_q[$];

  // Reference model state (spec-level: cycle count since reset release)
  int                 m_cyc;
  logic [ND-1:0][6:0] m_disp;
  logic [ND-1:0]      m_ddp;
  logic [ND-1:0][6:0] m_shadow;
  logic [ND-1:0]      m_sdp;
  logic               m_pending;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, m_cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc     = 0;
    m_disp    = '1;
    m_ddp     = '1;
    m_shadow  = '1;
    m_sdp     = '1;
    m_pending = 1'b0;
  endtask

  function automatic outs_t model_outs(input int c);
    outs_t o;
    int t;
    int dg;
    t  = c % DIV;
    dg = (c / DIV) % ND;
    o.seg = 7'h7F;
    o.dp  = 1'b1;
    o.an  = 4'hF;
    o.fd  = ((c % FRAME) == FRAME - 1);
    if (t >= BLK) begin
      o.seg    = m_disp[dg];
      o.dp     = m_ddp[dg];
      o.an[dg] = 1'b0;
    end
    return o;
  endfunction

  // One clock cycle: drive at negedge, predict, sample 1 time unit after posedge.
  task automatic step(input logic ld, input logic [27:0] s, input logic [3:0] d);
    outs_t e;
    outs_t a;
    bus_if.load = ld;
    if (ld) begin
      bus_if.seg_in = s;
      bus_if.dp_in  = d;
    end else begin
      bus_if.seg_in = 28'($urandom);
      bus_if.dp_in  = 4'($urandom);
    end
    if ((m_cyc % FRAME) == FRAME - 1) begin
      if (ld) begin
        m_disp = s;
        m_ddp  = d;
      end else if (m_pending) begin
        m_disp = m_shadow;
        m_ddp  = m_sdp;
      end
      m_pending = 1'b0;
    end else if (ld) begin
      m_shadow  = s;
      m_sdp     = d;
      m_pending = 1'b1;
    end
    m_cyc++;
    exp_q.push_back(model_outs(m_cyc));
    @(posedge clk);
    #1;
    a = {bus_if.seg_out, bus_if.dp_out, bus_if.an_out, bus_if.frame_done};
    e = exp_q.pop_front();
    chk("scoreboard {seg,dp,an,fd}", 32'(a), 32'(e));
    @(negedge clk);
  endtask

  task automatic run_to(input int off);
    while ((m_cyc % FRAME) != off) step(1'b0, 28'h0, 4'h0);
  endtask

  vec_t vecs[4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();

    vecs[0] = '{seg: {7'h30, 7'h24, 7'h79, 7'h40}, dp: 4'hF, load_at: 5,
                exp_seg: {7'h30, 7'h24, 7'h79, 7'h40}, exp_dp: 4'hF};
    vecs[1] = '{seg: {7'h12, 7'h12, 7'h12, 7'h12}, dp: 4'hA, load_at: 10,
                exp_seg: {7'h12, 7'h12, 7'h12, 7'h12}, exp_dp: 4'hA};
    vecs[2] = '{seg: {7'h00, 7'h00, 7'h00, 7'h00}, dp: 4'h0, load_at: FRAME - 1,
                exp_seg: {7'h00, 7'h00, 7'h00, 7'h00}, exp_dp: 4'h0};
    vecs[3] = '{seg: {7'h06, 7'h5B, 7'h4F, 7'h66}, dp: 4'h5, load_at: 0,
                exp_seg: {7'h06, 7'h5B, 7'h4F, 7'h66}, exp_dp: 4'h5};

    // Reset state held for three cycles
    rst = 1'b1;
    bus_if.load   = 1'b0;
    bus_if.seg_in = 28'h0;
    bus_if.dp_in  = 4'h0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst seg_out", 32'(bus_if.seg_out), 32'h7F);
      chk("rst dp_out", 32'(bus_if.dp_out), 32'h1);
      chk("rst an_out", 32'(bus_if.an_out), 32'hF);
      chk("rst frame_done", 32'(bus_if.frame_done), 32'h0);
      @(negedge clk);
    end
    rst = 1'b0;
    model_reset();

    // Table: load at a given frame offset, next frame must show the loaded digits
    for (int v = 0; v < 4; v++) begin
      run_to(vecs[v].load_at);
      step(1'b1, vecs[v].seg, vecs[v].dp);
      run_to(0);
      for (int k = 0; k < FRAME; k++) begin
        int t;
        int dg;
        step(1'b0, 28'h0, 4'h0);
        t  = m_cyc % DIV;
        dg = (m_cyc / DIV) % ND;
        if (t == 4 && (m_cyc % FRAME) != 0) begin
          chk($sformatf("tbl%0d seg d%0d", v, dg), 32'(bus_if.seg_out), 32'(vecs[v].exp_seg[dg]));
          chk($sformatf("tbl%0d dp d%0d", v, dg), 32'(bus_if.dp_out), 32'(vecs[v].exp_dp[dg]));
          chk($sformatf("tbl%0d an d%0d", v, dg), 32'(bus_if.an_out), 32'(~(4'b0001 << dg) & 4'hF));
        end
      end
    end

    // Two loads in one frame: only the second reaches the display
    run_to(3);
    step(1'b1, {4{7'h11}}, 4'h0);
    run_to(20);
    step(1'b1, {7'h01, 7'h02, 7'h03, 7'h04}, 4'h3);
    run_to(0);
    for (int k = 0; k < FRAME; k++) begin
      step(1'b0, 28'h0, 4'h0);
      if ((m_cyc % DIV) == 5) begin
        chk("two-load not A", 32'(bus_if.seg_out == 7'h11), 32'h0);
        chk("two-load B d", 32'(bus_if.seg_out), 32'(7'h04 - 7'((m_cyc / DIV) % ND)));
      end
    end

    // Reset during DRIVE of digit 2 with a pending load
    run_to(3);
    step(1'b1, {4{7'h08}}, 4'h0);
    run_to(2 * DIV + 4);
    chk("pre-rst an digit2", 32'(bus_if.an_out), 32'hB);
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst seg_out", 32'(bus_if.seg_out), 32'h7F);
    chk("mid rst dp_out", 32'(bus_if.dp_out), 32'h1);
    chk("mid rst an_out", 32'(bus_if.an_out), 32'hF);
    chk("mid rst frame_done", 32'(bus_if.frame_done), 32'h0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b0, 28'h0, 4'h0);
    chk("post-rst blank slot0", 32'(bus_if.an_out), 32'hF);
    run_to(4);
    chk("post-rst digit0 an", 32'(bus_if.an_out), 32'hE);
    chk("post-rst digit0 seg", 32'(bus_if.seg_out), 32'h7F);
    for (int k = 0; k < 2 * FRAME; k++) step(1'b0, 28'h0, 4'h0);
    chk("post-rst still blank", 32'(bus_if.seg_out), 32'h7F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
